// File: rtl/mult32_seq_pkg.sv
// Shared types and constants for the 32x32 sequential multiplier.
// Optional macro: MULT32_SEQ_EARLY_OUT_EN (single-step path for 16-bit operands).
package mult32_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  localparam int STEP_W = 2;
  localparam logic [STEP_W-1:0] LAST_STEP = 2'd3;

  localparam logic [5:0] SHIFT_S0 = 6'd0;
  localparam logic [5:0] SHIFT_S1 = 6'd16;
  localparam logic [5:0] SHIFT_S2 = 6'd16;
  localparam logic [5:0] SHIFT_S3 = 6'd32;

  function automatic logic [5:0] step_shift(
    input logic [STEP_W-1:0] s
  );
    logic [5:0] r;
    unique case (s)
      2'd0: r = SHIFT_S0;
      2'd1: r = SHIFT_S1;
      2'd2: r = SHIFT_S2;
      default: r = SHIFT_S3;
    endcase
    return r;
  endfunction

  // 16-bit half widened to the 18-bit signed DSP port.
  function automatic logic [17:0] ext18(
    input logic [15:0] half,
    input logic        signed_flag
  );
    return {{2{signed_flag & half[15]}}, half};
  endfunction

endpackage

// File: rtl/mult18x18_1c.sv
// 18x18 DSP multiplier with a registered 36-bit product.
// One cycle latency; product register updates only while en is high.
module mult18x18_1c #(
  parameter bit SIGNEDA = 1'b1,
  parameter bit SIGNEDB = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [17:0] a,
  input  logic [17:0] b,
  output logic [35:0] p
);

  logic [35:0] a_x;
  logic [35:0] b_x;
  logic [35:0] prod;
  logic [35:0] p_d;
  logic [35:0] p_q;

  // Widen operands and select the next product register value.
  always_comb begin
    a_x  = SIGNEDA ? {{18{a[17]}}, a} : {18'b0, a};
    b_x  = SIGNEDB ? {{18{b[17]}}, b} : {18'b0, b};
    prod = a_x * b_x;
    p_d  = en ? prod : p_q;
  end

  // Product register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) p_q <= '0;
    else     p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/mult32_seq.sv
// 32x32->64 multiplier built from four 18x18 partial products.
// Optional macro: MULT32_SEQ_EARLY_OUT_EN skips steps 1..3 for 16-bit operands.
module mult32_seq
  import mult32_seq_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_signed_a,
  input  logic             in_signed_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] last_q, last_d;
  logic [STEP_W-1:0] dstep_q, dstep_d;
  logic              vld_q, vld_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [63:0]       acc_q, acc_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic              mul_en;
  logic [17:0]       mul_a;
  logic [17:0]       mul_b;
  logic [35:0]       mul_p;
  logic [63:0]       prod_ext;

  // Partial-product operand select: step[1] picks A high, step[0] picks B high.
  always_comb begin
    mul_en   = (state_q == ISSUE);
    mul_a    = step_q[1] ? ext18(a_q[31:16], sa_q) : ext18(a_q[15:0], 1'b0);
    mul_b    = step_q[0] ? ext18(b_q[31:16], sb_q) : ext18(b_q[15:0], 1'b0);
    prod_ext = {{28{mul_p[35]}}, mul_p};
  end

  mult18x18_1c #(
    .SIGNEDA(1'b1),
    .SIGNEDB(1'b1)
  ) u_mul (
    .clk(clk),
    .rst(rst),
    .en (mul_en),
    .a  (mul_a),
    .b  (mul_b),
    .p  (mul_p)
  );

  // Sequencer next-state, accumulation and registered handshake outputs.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    last_d      = last_q;
    a_d         = a_q;
    b_d         = b_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    tag_d       = tag_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    vld_d       = (state_q == ISSUE);
    dstep_d     = step_q;

    if (vld_q) begin
      acc_d = acc_q + (prod_ext << step_shift(dstep_q));
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = in_a;
          b_d        = in_b;
          sa_d       = in_signed_a;
          sb_d       = in_signed_b;
          tag_d      = in_tag;
          acc_d      = '0;
          step_d     = '0;
          state_d    = ISSUE;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
`ifdef MULT32_SEQ_EARLY_OUT_EN
          last_d = (in_a[31:16] == 16'h0 && in_b[31:16] == 16'h0)
                   ? '0 : LAST_STEP;
`else
          last_d = LAST_STEP;
`endif
        end
      end
      ISSUE: begin
        if (step_q == last_q) state_d = DRAIN;
        else                  step_d  = step_q + 1'b1;
      end
      DRAIN: begin
        state_d     = DONE;
        out_valid_d = 1'b1;
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      last_q      <= LAST_STEP;
      dstep_q     <= '0;
      vld_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      tag_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      last_q      <= last_d;
      dstep_q     <= dstep_d;
      vld_q       <= vld_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      tag_q       <= tag_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = acc_q;
  assign out_tag   = tag_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mult32_seq.sv
// Scoreboard bench for mult32_seq: random and directed products vs a
// 64-bit arithmetic reference, with latency, backpressure and reset-abort checks.
module tb_mult32_seq;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_signed_a;
  logic             in_signed_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_p;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  logic rand_ready = 1'b0;
  logic rnd_r = 1'b1;
  logic fix_r = 1'b1;
  assign out_ready = rand_ready ? rnd_r : fix_r;

  always #5 clk = ~clk;

  mult32_seq #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_signed_a(in_signed_a),
    .in_signed_b(in_signed_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_p      (out_p),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  typedef struct {
    logic [63:0]      p;
    logic [TAG_W-1:0] tag;
    int               acc;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) rnd_r <= ($urandom_range(0, 3) != 0);

  function automatic logic [63:0] ref_mul(
    input logic [31:0] a, input logic [31:0] b,
    input logic sa, input logic sb_f
  );
    logic [63:0] x;
    logic [63:0] y;
    x = {{32{sa & a[31]}}, a};
    y = {{32{sb_f & b[31]}}, b};
    return x * y;
  endfunction

  function automatic int lat_of(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT32_SEQ_EARLY_OUT_EN
    return (a[31:16] == 16'h0 && b[31:16] == 16'h0) ? 2 : 5;
`else
    return 5;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic sa, input logic sb_f,
                       input logic [TAG_W-1:0] tag);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      return;
    end
    in_valid    = 1'b1;
    in_a        = a;
    in_b        = b;
    in_signed_a = sa;
    in_signed_b = sb_f;
    in_tag      = tag;
    e.p   = ref_mul(a, b, sa, sb_f);
    e.tag = tag;
    e.acc = cyc + 1;
    e.lat = lat_of(a, b);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: latency on first valid, product/tag on each transfer.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) check("spurious_valid", 64'd1, 64'd0);
        else check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        check("product", out_p, sb[0].p);
        check("tag", 64'(out_tag), 64'(sb[0].tag));
        void'(sb.pop_front());
      end
      prev_v = out_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [63:0]      p0;
    logic [TAG_W-1:0] t0;
    int               n;
    logic [31:0]      ra;
    logic [31:0]      rb;

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_signed_a = 1'b0;
    in_signed_b = 1'b0;
    in_tag = '0;
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_p", out_p, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'hA);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'h1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'h2);
    issue(32'h0000_1234, 32'h0000_0010, 1'b0, 1'b0, 4'h3);
    issue(32'h0001_0000, 32'h0000_0001, 1'b0, 1'b0, 4'h4);
    drain();

    // Backpressure: hold out_ready low for 10 cycles.
    @(negedge clk);
    fix_r = 1'b0;
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 4'h6);
    n = 0;
    tick();
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    p0 = out_p;
    t0 = out_tag;
    repeat (10) begin
      tick();
      check("bp_p_stable", out_p, p0);
      check("bp_tag_stable", 64'(out_tag), 64'(t0));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    fix_r = 1'b1;
    tick();
    check("bp_idle_ready", 64'(in_ready), 64'd1);
    check("bp_idle_valid", 64'(out_valid), 64'd0);
    check("bp_idle_busy", 64'(busy), 64'd0);
    issue(32'd7, 32'd6, 1'b0, 1'b0, 4'h7);
    drain();

    // Reset abort during step 2.
    issue(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b1, 4'h5);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(32'd3, 32'd5, 1'b0, 1'b0, 4'h8);
    drain();

    // Random traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 2) == 0) ra = ra & 32'h0000_FFFF;
      if ($urandom_range(0, 2) == 0) rb = rb & 32'h0000_FFFF;
      issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            TAG_W'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult32_seq.md
Name: mult32_seq

Overview:
- Sequencer that computes a full 32x32 -> 64-bit product on one 18x18 signed DSP multiplier (mult18x18_1c: registered output, one cycle latency).
- Splits each operand into 16-bit halves and issues four partial products back to back.
- Accumulates the partial products and returns the result over a valid/ready handshake.
- Sits between the CPU execute stage (MUL/MULH/MULHU/MULHSU) and the DSP slice.

Parameters:
TAG_W, 4, width of the opaque tag carried from request to response.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_a  in  32  operand A
in_b  in  32  operand B
in_signed_a  in  1  1 = treat A as two's complement
in_signed_b  in  1  1 = treat B as two's complement
in_tag  in  TAG_W  request tag
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid & out_ready
out_p  out  64  full product
out_tag  out  TAG_W  tag of the request that produced out_p
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: one clock `clk`; reset `rst` is asynchronous and active-high.
  - During reset: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_p = 0, out_tag = 0, accumulator = 0, step = 0.
  - The multiplier's rst is driven from `rst`.
- States: IDLE, ISSUE, DRAIN, DONE.
- in_ready = (state == IDLE). There is no accept in the same cycle that DONE completes.
- IDLE, on accept:
  - Latch operands, sign flags and tag.
  - Clear the accumulator, set step = 0, go to ISSUE.
- Operand halves, each presented to the multiplier as 18 bits:
  - Low halves: {2'b0, x[15:0]}.
  - High halves: signed ? {2{x[31]}, x[31:16]} : {2'b0, x[31:16]}.
- ISSUE, steps 0..3, one per cycle, multiplier enable = 1:
  - step 0: AL*BL, shift 0
  - step 1: AL*BH, shift 16
  - step 2: AH*BL, shift 16
  - step 3: AH*BH, shift 32
  - After step 3, go to DRAIN.
- Accumulation:
  - The 36-bit product P of step k is registered on the edge that ends step k.
  - On the following edge: acc += sign_extend64(P) << shift(k).
  - All arithmetic is mod 2^64.
  - Shift is tracked by a one-cycle-delayed copy of step.
- Multiplier enable is 1 in ISSUE and 0 elsewhere. The multiplier output is ignored outside the delayed-valid window.
- DRAIN: accumulate the step-3 product, go to DONE.
- DONE:
  - out_valid = 1; out_p = acc; out_tag = latched tag.
  - Both hold stable until out_ready; then go to IDLE and clear out_valid.
- Timing: accept at edge E0 -> out_valid high after edge E5 (five-cycle latency). Minimum spacing between accepts is 7 cycles.
- in_* changes while not in IDLE are ignored.
- rst mid-operation aborts the operation immediately. No result is produced.

Optional Feature:
- Macro MULT32_SEQ_EARLY_OUT_EN.
- When defined:
  - If in_a[31:16] == 0 and in_b[31:16] == 0 at accept, issue only step 0, then go to DRAIN.
  - out_valid is high after edge E2.
  - busy and all handshakes are otherwise unchanged.
- When undefined: all four steps are always issued, with fixed 5-cycle latency.

Decomposition:
- Package mult32_seq_pkg holds:
  - state enum (IDLE, ISSUE, DRAIN, DONE);
  - step width (2) and LAST_STEP = 3;
  - shift-per-step constants;
  - function ext18(half, signed_flag).
- Sub-module: one instance of the existing mult18x18_1c.
  - SIGNEDA/SIGNEDB are fixed signed.
  - en is the ISSUE strobe.
- No other sub-module.

Test Plan:
- Unsigned A=0xFFFFFFFF, B=0xFFFFFFFF -> out_p=0xFFFFFFFE00000001; out_valid exactly 5 edges after accept; out_tag echoes in_tag=0xA.
- Signed both, A=0xFFFFFFFF (-1), B=0xFFFFFFFF (-1) -> out_p=0x0000000000000001.
- Signed A=0x80000000, unsigned B=0xFFFFFFFF -> out_p=0x8000000080000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Expect out_p/out_tag stable, in_ready=0, busy=1.
  - On release, IDLE next cycle; a new request 7*6 -> 42 is accepted and correct.
- Reset abort: assert rst during ISSUE step 2.
  - Expect out_valid=0, in_ready=1 immediately.
  - After release, 3*5 -> 15 with correct latency and no stale accumulation.
- Early-out: A=0x1234, B=0x10 unsigned -> 0x12340.
  - Latency 2 edges with MULT32_SEQ_EARLY_OUT_EN, 5 without.
  - A=0x10000, B=1 takes 5 edges in both builds.
